uart_tx_frame_gen: RTL and testbench

Parametrised successor to the fixed 8N1 rs232_ser GSE/FPGA serializer. It pulls bytes from a show-ahead FIFO and shifts them out LSB-first on a UART line. Data width, parity mode and stop-bit count are set at build time, and the bit period is derived from clock and baud parameters. It sits between the command/response FIFOs and GPIO_1 UART pins in de0_pulse_gen_top; it is also instanced in the bench as the FT232R model.

---
 rtl/uart_tx_frame_gen_pkg.sv | 23 ++
 rtl/uart_tx_frame_gen_baud_tick.sv | 31 +++
 rtl/uart_tx_frame_gen.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_frame_gen.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_frame_gen_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes, baud divisor helper.
// No logic; constants and a pure function evaluated at elaboration time.
// Imported by the serializer and reusable by the matching deserializer.
package uart_tx_frame_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per bit period, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_frame_gen_baud_tick.sv
// Bit-period counter: counts 0..P_DIV-1 and flags the last clock of each period.
// Latency: tick is combinational from the count; i_clr holds the count at zero.
// No backpressure; free-running whenever i_clr is low.
module uart_baud_tick #(
    parameter int P_DIV = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (P_DIV > 2) ? $clog2(P_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(P_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count through one bit period, wrapping at the period end or when cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == C_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = !i_clr && (r_cnt == C_LAST);

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART frame serializer: pops words from a show-ahead FIFO, sends start/data(LSB first)/parity/stop.
// Latency: pop cycle, then start bit on tx the next clock; frame = bits*P_DIV + 1 clocks.
// Backpressure: pops only in IDLE when FIFO non-empty; optional frame_cnt via UART_TX_FRAME_CNT_EN.
module uart_tx_frame_gen
    import uart_tx_frame_gen_pkg::*;
#(
    parameter int P_CLK_FREQ_HZ = 50_000_000,
    parameter int P_BAUD_RATE   = 3_000_000,
    parameter int P_DATA_BITS   = 8,
    parameter int P_PARITY      = 0,
    parameter int P_STOP_BITS   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [P_DATA_BITS-1:0] tx_fifo_data,
    input  logic                   tx_fifo_empty,
    output logic                   tx_fifo_rd_en,
    output logic                   tx,
    output logic                   tx_busy
`ifdef UART_TX_FRAME_CNT_EN
    ,
    output logic [31:0]            frame_cnt
`endif
);

    localparam int P_DIV = calc_div(P_CLK_FREQ_HZ, P_BAUD_RATE);
    localparam int BW    = $clog2(P_DATA_BITS);
    localparam logic [BW-1:0] C_LAST_BIT = BW'(P_DATA_BITS - 1);

    if (P_DIV < 2) begin : g_bad_div
        $error("uart_tx_frame_gen: bit divisor below 2");
    end
    if ((P_DATA_BITS < 5) || (P_DATA_BITS > 9)) begin : g_bad_width
        $error("uart_tx_frame_gen: data bits must be 5..9");
    end
    if ((P_PARITY < PAR_NONE) || (P_PARITY > PAR_EVEN)) begin : g_bad_parity
        $error("uart_tx_frame_gen: parity mode must be 0..2");
    end
    if ((P_STOP_BITS < 1) || (P_STOP_BITS > 2)) begin : g_bad_stop
        $error("uart_tx_frame_gen: stop bits must be 1 or 2");
    end

    uart_state_t            r_state;
    uart_state_t            w_state_nxt;
    logic                   r_en;
    logic [P_DATA_BITS-1:0] r_shift;
    logic [P_DATA_BITS-1:0] w_shift_nxt;
    logic [P_DATA_BITS-1:0] r_word;
    logic [BW-1:0]          r_bit_idx;
    logic [BW-1:0]          w_bit_idx_nxt;
    logic                   r_stop_idx;
    logic                   w_stop_idx_nxt;
    logic                   r_tx;
    logic                   w_tx_nxt;
    logic                   w_pop;
    logic                   w_tick;
    logic                   w_last_stop;
    logic                   w_parity;

    // Counter held at zero in IDLE so START always begins a fresh period.
    uart_baud_tick #(
        .P_DIV (P_DIV)
    ) u_baud_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (r_state == S_IDLE),
        .o_tick (w_tick)
    );

    // Parity from the latched word so FIFO head changes mid-frame cannot leak in.
    assign w_parity    = (P_PARITY == PAR_ODD) ? ~(^r_word) : ^r_word;
    assign w_last_stop = (P_STOP_BITS == 1) || r_stop_idx;

    // Pops are held off for one clock after reset release so none can occur in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en <= 1'b0;
        end else begin
            r_en <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, pop strobe and next shift/index values.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_en && !tx_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = tx_fifo_data;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_idx == C_LAST_BIT) begin
                        w_stop_idx_nxt = 1'b0;
                        w_state_nxt    = (P_PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_stop_idx_nxt = 1'b0;
                    w_state_nxt    = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (w_last_stop) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line level for the coming clock, derived from where the FSM is heading.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = w_parity;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // Datapath registers: shift register, latched word, indices and registered line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_word     <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_tx       <= w_tx_nxt;
            if (w_pop) begin
                r_word <= tx_fifo_data;
            end
        end
    end

    assign tx            = r_tx;
    assign tx_fifo_rd_en = w_pop;
    assign tx_busy       = (r_state != S_IDLE) || w_pop;

`ifdef UART_TX_FRAME_CNT_EN
    logic        w_frame_done;
    logic [31:0] r_frame_cnt;

    assign w_frame_done = (r_state == S_STOP) && w_tick && w_last_stop;

    // Completed-frame counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 32'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    // Frame counter not built; serial behaviour is unchanged.
`endif

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Bench for uart_tx_frame_gen: two builds (8N1 and 7-bit odd parity, 2 stop) fed from FIFO models.
// Stimulus pushes each word into a FIFO model and its hand-computed bit pattern into a scoreboard.
// Monitors decode every popped frame cycle by cycle and compare against the scoreboard.
module tb_uart_tx_frame_gen;

    typedef struct packed {
        logic        abort;
        logic [3:0]  len;
        logic [11:0] bits;
    } exp_t;

    localparam int DIV = 17;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_bad;

    logic [1:0] rd_en;
    logic [1:0] tx;
    logic [1:0] busy;
`ifdef UART_TX_FRAME_CNT_EN
    logic [31:0] frame_cnt [2];
`endif

    logic [8:0] fq [2][$];
    exp_t       sb [2][$];
    int         pop_cyc [2][$];
    int         last_run [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cfg%0d %s: got %0h expected %0h (cycle %0d)", g, nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg_g
        localparam int NB  = (g == 0) ? 8 : 7;
        localparam int PAR = (g == 0) ? 0 : 1;
        localparam int STP = (g == 0) ? 1 : 2;

        logic [NB-1:0] fifo_data;
        logic          fifo_empty;

        uart_tx_frame_gen #(
            .P_CLK_FREQ_HZ (50_000_000),
            .P_BAUD_RATE   (3_000_000),
            .P_DATA_BITS   (NB),
            .P_PARITY      (PAR),
            .P_STOP_BITS   (STP)
        ) dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .tx_fifo_data  (fifo_data),
            .tx_fifo_empty (fifo_empty),
            .tx_fifo_rd_en (rd_en[g]),
            .tx            (tx[g]),
            .tx_busy       (busy[g])
`ifdef UART_TX_FRAME_CNT_EN
            ,
            .frame_cnt     (frame_cnt[g])
`endif
        );

        // Show-ahead FIFO model: head presented after each rising edge, popped on rd_en.
        initial begin
            logic pop_now;
            fifo_empty = 1'b1;
            fifo_data  = '0;
            forever begin
                @(negedge clk);
                pop_now = rd_en[g];
                @(posedge clk);
                #1;
                if (pop_now && fq[g].size() > 0) void'(fq[g].pop_front());
                fifo_empty = (fq[g].size() == 0);
                fifo_data  = (fq[g].size() > 0) ? fq[g][0][NB-1:0] : '0;
            end
        end

        // Length of the most recent tx_busy high run.
        initial begin
            int run;
            run = 0;
            forever begin
                @(negedge clk);
                if (busy[g]) run++;
                else if (run != 0) begin
                    last_run[g] = run;
                    run = 0;
                end
            end
        end

        // Frame monitor: on each pop, check every bit period against the scoreboard entry.
        initial begin
            exp_t e;
            int   bad;
            logic aborted;
            forever begin
                @(negedge clk);
                while (rd_en[g] && rst_n) begin
                    pop_cyc[g].push_back(cyc);
                    if (sb[g].size() == 0) begin
                        check(g, "unexpected_pop", 1, 0);
                        e = '0;
                    end else begin
                        e = sb[g].pop_front();
                    end
                    check(g, "pop_cycle_busy", busy[g], 1);
                    check(g, "pop_cycle_tx", tx[g], 1);
                    aborted = 1'b0;
                    for (int b = 0; b < int'(e.len) && !aborted; b++) begin
                        bad = 0;
                        for (int c = 0; c < DIV; c++) begin
                            @(negedge clk);
                            if (!rst_n) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (tx[g] !== e.bits[b] || busy[g] !== 1'b1) bad++;
                        end
                        if (!aborted) check(g, $sformatf("bit%0d_bad_cycles", b), bad, 0);
                    end
                    check(g, "frame_aborted", aborted, e.abort);
                    if (aborted) break;
                    @(negedge clk);
                    check(g, "gap_tx_idle", tx[g], 1);
                    if (sb[g].size() == 0) begin
                        check(g, "idle_rd_en", rd_en[g], 0);
                        check(g, "idle_busy", busy[g], 0);
                    end
                end
            end
        end
    end

    task automatic push(input int g, input logic [8:0] w, input logic [11:0] bits,
                        input logic [3:0] len, input logic ab);
        exp_t e;
        e.abort = ab;
        e.len   = len;
        e.bits  = bits;
        fq[g].push_back(w);
        sb[g].push_back(e);
    endtask

    task automatic wait_idle(input int g, input int max);
        int n;
        n = 0;
        while (n < max && !(sb[g].size() == 0 && fq[g].size() == 0 && busy[g] == 1'b0)) begin
            @(negedge clk);
            n++;
        end
        check(g, "idle_within_budget", (n < max), 1);
        @(posedge clk);
    endtask

    task automatic wait_pop(input int g, input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_en[g] && n < max);
        check(g, "pop_seen", rd_en[g], 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bad;
        logic [7:0] b;
`ifdef UART_TX_FRAME_CNT_EN
        logic [31:0] fc0;
`endif
        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Scenario 1 word queued during reset: must not pop until released.
        push(0, 9'h0A5, 12'h34A, 4'd10, 1'b0);
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check(g, "reset_tx", tx[g], 1);
            check(g, "reset_busy", busy[g], 0);
            check(g, "reset_rd_en", rd_en[g], 0);
`ifdef UART_TX_FRAME_CNT_EN
            check(g, "reset_frame_cnt", frame_cnt[g], 0);
`endif
        end
        rst_n = 1'b1;

        wait_idle(0, 400);
        check(0, "a5_pop_count", pop_cyc[0].size(), 1);
        check(0, "a5_busy_clocks", last_run[0], 171);

        // 7-bit odd parity, 2 stop bits.
        push(1, 9'h041, 12'h782, 4'd11, 1'b0);
        wait_idle(1, 400);
        check(1, "41_busy_clocks", last_run[1], 188);
        pop_cyc[1].delete();
        push(1, 9'h007, 12'h60E, 4'd11, 1'b0);
        push(1, 9'h07F, 12'h6FE, 4'd11, 1'b0);
        push(1, 9'h000, 12'h700, 4'd11, 1'b0);
        wait_idle(1, 1000);
        check(1, "odd_pop_count", pop_cyc[1].size(), 3);
        if (pop_cyc[1].size() == 3) begin
            check(1, "odd_spacing_1", pop_cyc[1][1] - pop_cyc[1][0], 188);
            check(1, "odd_spacing_2", pop_cyc[1][2] - pop_cyc[1][1], 188);
        end
        check(1, "odd_busy_clocks", last_run[1], 3 * 188);

        // 17-byte back-to-back burst.
        pop_cyc[0].delete();
`ifdef UART_TX_FRAME_CNT_EN
        fc0 = frame_cnt[0];
`endif
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 37 + 3);
            push(0, {1'b0, b}, {2'b00, 1'b1, b, 1'b0}, 4'd10, 1'b0);
        end
        wait_idle(0, 17 * 171 + 200);
        check(0, "burst_pop_count", pop_cyc[0].size(), 17);
        if (pop_cyc[0].size() == 17) begin
            for (int i = 1; i < 17; i++)
                check(0, $sformatf("burst_spacing_%0d", i), pop_cyc[0][i] - pop_cyc[0][i-1], 171);
        end
        check(0, "burst_busy_clocks", last_run[0], 17 * 171);
`ifdef UART_TX_FRAME_CNT_EN
        check(0, "burst_frame_cnt", frame_cnt[0], fc0 + 32'd17);
`endif

        // Reset during data bit 3 of 0xFF; queued 0x3C must follow cleanly.
        push(0, 9'h0FF, 12'h3FE, 4'd10, 1'b1);
        push(0, 9'h03C, 12'h278, 4'd10, 1'b0);
        wait_pop(0, 300);
        repeat (74) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check(0, "async_reset_busy", busy[0], 0);
        check(0, "async_reset_tx", tx[0], 1);
        @(negedge clk);
        check(0, "reset_no_pop", rd_en[0], 0);
`ifdef UART_TX_FRAME_CNT_EN
        check(0, "reset_clears_cnt", frame_cnt[0], 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle(0, 500);
        check(0, "post_reset_busy_clocks", last_run[0], 171);

        // Reset during the start bit: line must return high with no clock edge.
        push(0, 9'h055, 12'h2AA, 4'd10, 1'b1);
        push(0, 9'h080, 12'h300, 4'd10, 1'b0);
        wait_pop(0, 300);
        repeat (5) @(posedge clk);
        #1;
        check(0, "start_bit_low", tx[0], 0);
        #2 rst_n = 1'b0;
        #1;
        check(0, "async_reset_start_tx", tx[0], 1);
        check(0, "async_reset_start_busy", busy[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle(0, 500);
        check(0, "post_reset2_busy_clocks", last_run[0], 171);

        // Long empty FIFO: line idle, no pops, not busy.
        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (rd_en !== 2'b00 || busy !== 2'b00 || tx !== 2'b11) bad++;
        end
        check(0, "quiet_bad_cycles", bad, 0);
        check(0, "scoreboard_drained", sb[0].size(), 0);
        check(1, "scoreboard_drained", sb[1].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
